// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer: state encoding and flush counter width.
package pipe_ctrl_pkg;

  localparam int FLUSH_CNT_W = 3;

  typedef enum logic [1:0] {
    PC_ST_IDLE  = 2'd0,
    PC_ST_RUN   = 2'd1,
    PC_ST_FLUSH = 2'd2,
    PC_ST_HALT  = 2'd3
  } pc_state_t;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Combinational load-use comparator: an ID operand matches the GPR a load in EX is about to write.
module pipe_ctrl_hazard_detect #(
  parameter int GPR_W = 4
) (
  input  logic             id_valid,
  input  logic             id_src_used,
  input  logic [GPR_W-1:0] id_src_gp,
  input  logic             id_tgt_used,
  input  logic [GPR_W-1:0] id_tgt_gp,
  input  logic             ex_valid,
  input  logic             ex_is_load,
  input  logic             ex_wr_en,
  input  logic [GPR_W-1:0] ex_tgt_gp,
  output logic             hazard
);

  logic load_wr;
  logic src_hit;
  logic tgt_hit;

  assign load_wr = ex_valid & ex_is_load & ex_wr_en;
  assign src_hit = id_src_used & (id_src_gp == ex_tgt_gp);
  assign tgt_hit = id_tgt_used & (id_tgt_gp == ex_tgt_gp);
  assign hazard  = load_wr & id_valid & (src_hit | tgt_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer around EX: start/halt, load-use interlock and taken-branch flush.
// Define PIPE_CTRL_STALL_CNT_EN to build the saturating load-use stall counter.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int GPR_W        = 4,
  parameter int STALL_CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   run_req,
  input  logic                   halt_in,
  input  logic                   branch_taken_in,
  input  logic [23:0]            branch_tgt_in,
  input  logic                   id_valid,
  input  logic                   id_src_used,
  input  logic [GPR_W-1:0]       id_src_gp,
  input  logic                   id_tgt_used,
  input  logic [GPR_W-1:0]       id_tgt_gp,
  input  logic                   ex_valid,
  input  logic                   ex_is_load,
  input  logic                   ex_wr_en,
  input  logic [GPR_W-1:0]       ex_tgt_gp,
  output logic                   en_if,
  output logic                   en_id,
  output logic                   en_ex,
  output logic                   bubble_ex,
  output logic                   flush_fe,
  output logic                   pc_load,
  output logic [23:0]            pc_load_val,
  output logic                   halted,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  pc_state_t              state;
  pc_state_t              state_nxt;
  logic [FLUSH_CNT_W-1:0] flush_cnt;
  logic [FLUSH_CNT_W-1:0] flush_cnt_nxt;
  logic                   hazard;

  pipe_ctrl_hazard_detect #(
    .GPR_W(GPR_W)
  ) u_hazard (
    .id_valid   (id_valid),
    .id_src_used(id_src_used),
    .id_src_gp  (id_src_gp),
    .id_tgt_used(id_tgt_used),
    .id_tgt_gp  (id_tgt_gp),
    .ex_valid   (ex_valid),
    .ex_is_load (ex_is_load),
    .ex_wr_en   (ex_wr_en),
    .ex_tgt_gp  (ex_tgt_gp),
    .hazard     (hazard)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= PC_ST_IDLE;
      flush_cnt <= '0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_cnt_nxt;
    end
  end

  // Controls act in the cycle they are decided; halt wins over branch, branch over hazard.
  always_comb begin
    state_nxt     = state;
    flush_cnt_nxt = flush_cnt;
    en_if         = 1'b0;
    en_id         = 1'b0;
    en_ex         = 1'b0;
    bubble_ex     = 1'b0;
    flush_fe      = 1'b0;
    pc_load       = 1'b0;
    halted        = 1'b0;
    case (state)
      PC_ST_RUN: begin
        if (halt_in) begin
          state_nxt = PC_ST_HALT;
        end else if (branch_taken_in) begin
          {en_if, en_id, en_ex} = '1;
          bubble_ex     = 1'b1;
          flush_fe      = 1'b1;
          pc_load       = 1'b1;
          flush_cnt_nxt = FLUSH_CNT_W'(FLUSH_CYCLES - 1);
          state_nxt     = (FLUSH_CYCLES == 1) ? PC_ST_RUN : PC_ST_FLUSH;
        end else if (hazard) begin
          en_ex     = 1'b1;
          bubble_ex = 1'b1;
        end else begin
          {en_if, en_id, en_ex} = '1;
        end
      end
      PC_ST_FLUSH: begin
        // Wrong-path slots: hazards and branches seen here are not real.
        if (halt_in) begin
          state_nxt = PC_ST_HALT;
        end else begin
          {en_if, en_id, en_ex} = '1;
          bubble_ex     = 1'b1;
          flush_cnt_nxt = flush_cnt - FLUSH_CNT_W'(1);
          if (flush_cnt <= FLUSH_CNT_W'(1)) state_nxt = PC_ST_RUN;
        end
      end
      default: begin
        halted = 1'b1;
        if (run_req) state_nxt = PC_ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          pc_load_val <= '0;
    else if (pc_load) pc_load_val <= branch_tgt_in;
  end

`ifdef PIPE_CTRL_STALL_CNT_EN
  logic                   stall_inc;
  logic [STALL_CNT_W-1:0] stall_q;

  function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
    return (&v) ? v : v + STALL_CNT_W'(1);
  endfunction

  assign stall_inc = (state == PC_ST_RUN) & ~halt_in & ~branch_taken_in & hazard;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            stall_q <= '0;
    else if (stall_inc) stall_q <= sat_inc(stall_q);
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl against a cycle-level behavioural model of the sequencer rules.
module tb_pipe_ctrl;

  localparam int FC   = 2;
  localparam int GW   = 4;
  localparam int SW   = 16;
  localparam int SMAX = (1 << SW) - 1;

  logic          clk = 1'b0;
  logic          rst, run_req, halt_in, branch_taken_in;
  logic [23:0]   branch_tgt_in;
  logic          id_valid, id_src_used, id_tgt_used, ex_valid, ex_is_load, ex_wr_en;
  logic [GW-1:0] id_src_gp, id_tgt_gp, ex_tgt_gp;
  logic          en_if, en_id, en_ex, bubble_ex, flush_fe, pc_load, halted;
  logic [23:0]   pc_load_val;
  logic [SW-1:0] stall_cnt;

  int n_run  = 0;
  int n_fail = 0;

  // Model: running flag, remaining wrong-path cycles, last branch target, stall total.
  bit            m_run;
  int            m_wrong;
  logic [23:0]   m_pcv;
  int            m_stalls;
  logic [6:0]    e_ctl;
  logic [SW-1:0] e_stall;

  wire [6:0] act_ctl = {en_if, en_id, en_ex, bubble_ex, flush_fe, pc_load, halted};

  always #5 clk = ~clk;

  pipe_ctrl #(.FLUSH_CYCLES(FC), .GPR_W(GW), .STALL_CNT_W(SW)) dut (
    .clk(clk), .rst(rst), .run_req(run_req), .halt_in(halt_in),
    .branch_taken_in(branch_taken_in), .branch_tgt_in(branch_tgt_in),
    .id_valid(id_valid), .id_src_used(id_src_used), .id_src_gp(id_src_gp),
    .id_tgt_used(id_tgt_used), .id_tgt_gp(id_tgt_gp), .ex_valid(ex_valid),
    .ex_is_load(ex_is_load), .ex_wr_en(ex_wr_en), .ex_tgt_gp(ex_tgt_gp),
    .en_if(en_if), .en_id(en_id), .en_ex(en_ex), .bubble_ex(bubble_ex),
    .flush_fe(flush_fe), .pc_load(pc_load), .pc_load_val(pc_load_val),
    .halted(halted), .stall_cnt(stall_cnt)
  );

  function automatic bit model_haz();
    return ex_valid && ex_is_load && ex_wr_en && id_valid &&
           ((id_src_used && id_src_gp == ex_tgt_gp) || (id_tgt_used && id_tgt_gp == ex_tgt_gp));
  endfunction

  function automatic void model_eval();
    if (!m_run)                e_ctl = 7'b0000001;
    else if (halt_in)          e_ctl = 7'b0000000;
    else if (m_wrong > 0)      e_ctl = 7'b1111000;
    else if (branch_taken_in)  e_ctl = 7'b1111110;
    else if (model_haz())      e_ctl = 7'b0011000;
    else                       e_ctl = 7'b1110000;
`ifdef PIPE_CTRL_STALL_CNT_EN
    e_stall = SW'(m_stalls);
`else
    e_stall = '0;
`endif
  endfunction

  function automatic void model_advance();
    if (!m_run) begin
      if (run_req) m_run = 1'b1;
    end else if (halt_in) begin
      m_run   = 1'b0;
      m_wrong = 0;
    end else if (m_wrong > 0) begin
      m_wrong--;
    end else if (branch_taken_in) begin
      m_pcv   = branch_tgt_in;
      m_wrong = FC - 1;
    end else if (model_haz() && m_stalls < SMAX) begin
      m_stalls++;
    end
  endfunction

  function automatic void model_reset();
    m_run = 1'b0; m_wrong = 0; m_pcv = '0; m_stalls = 0;
  endfunction

  task automatic quiet_inputs();
    run_req = 0; halt_in = 0; branch_taken_in = 0; branch_tgt_in = '0;
    id_valid = 0; id_src_used = 0; id_src_gp = '0; id_tgt_used = 0; id_tgt_gp = '0;
    ex_valid = 0; ex_is_load = 0; ex_wr_en = 0; ex_tgt_gp = '0;
  endtask

  task automatic load_r3_case(input bit src_hits);
    ex_valid = 1; ex_is_load = 1; ex_wr_en = 1; ex_tgt_gp = 4'd3; id_valid = 1;
    id_src_used = src_hits; id_src_gp = 4'd3; id_tgt_used = 1; id_tgt_gp = 4'd5;
  endtask

  task automatic test_reset();
    quiet_inputs();
    rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    model_eval();
    n_run++;
    if ({act_ctl, pc_load_val, stall_cnt} !== {7'b0000001, 24'h0, 16'h0}) begin
      n_fail++;
      $display("FAIL reset ctl/pcv/stall act=%b/%h/%h req=%b/%h/%h",
               act_ctl, pc_load_val, stall_cnt, 7'b0000001, 24'h0, 16'h0);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_start();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      quiet_inputs();
      run_req = (c == 0);
      #1;
      model_eval();
      n_run++;
      if ({act_ctl, pc_load_val, stall_cnt} !== {e_ctl, m_pcv, e_stall}) begin
        n_fail++;
        $display("FAIL start[%0d] ctl/pcv/stall act=%b/%h/%h req=%b/%h/%h",
                 c, act_ctl, pc_load_val, stall_cnt, e_ctl, m_pcv, e_stall);
      end
      if (c == 1) begin
        n_run++;
        if (act_ctl !== 7'b1110000) begin
          n_fail++;
          $display("FAIL start_run ctl act=%b req=%b", act_ctl, 7'b1110000);
        end
      end
      model_advance();
    end
  endtask

  task automatic test_load_use();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      quiet_inputs();
      case (c)
        0: load_r3_case(1'b1);
        2: load_r3_case(1'b0);
        default: ;
      endcase
      #1;
      model_eval();
      n_run++;
      if ({act_ctl, pc_load_val, stall_cnt} !== {e_ctl, m_pcv, e_stall}) begin
        n_fail++;
        $display("FAIL load_use[%0d] ctl/pcv/stall act=%b/%h/%h req=%b/%h/%h",
                 c, act_ctl, pc_load_val, stall_cnt, e_ctl, m_pcv, e_stall);
      end
      if (c == 0) begin
        n_run++;
        if (act_ctl !== 7'b0011000) begin
          n_fail++;
          $display("FAIL load_use_stall ctl act=%b req=%b", act_ctl, 7'b0011000);
        end
      end
      model_advance();
    end
  endtask

  task automatic test_branch_flush();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      quiet_inputs();
      if (c == 0) begin
        branch_taken_in = 1; branch_tgt_in = 24'h000123;
      end else if (c == 1) begin
        load_r3_case(1'b1);
        branch_taken_in = 1; branch_tgt_in = 24'h00BEEF;
      end
      #1;
      model_eval();
      n_run++;
      if ({act_ctl, pc_load_val, stall_cnt} !== {e_ctl, m_pcv, e_stall}) begin
        n_fail++;
        $display("FAIL branch[%0d] ctl/pcv/stall act=%b/%h/%h req=%b/%h/%h",
                 c, act_ctl, pc_load_val, stall_cnt, e_ctl, m_pcv, e_stall);
      end
      if (c == 2) begin
        n_run++;
        if (pc_load_val !== 24'h000123) begin
          n_fail++;
          $display("FAIL branch_target pcv act=%h req=%h", pc_load_val, 24'h000123);
        end
      end
      model_advance();
    end
  endtask

  task automatic test_halt_vs_branch();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      quiet_inputs();
      if (c == 0) begin
        halt_in = 1; branch_taken_in = 1; branch_tgt_in = 24'hABCDEF;
      end
      run_req = (c == 2);
      #1;
      model_eval();
      n_run++;
      if ({act_ctl, pc_load_val, stall_cnt} !== {e_ctl, m_pcv, e_stall}) begin
        n_fail++;
        $display("FAIL halt_branch[%0d] ctl/pcv/stall act=%b/%h/%h req=%b/%h/%h",
                 c, act_ctl, pc_load_val, stall_cnt, e_ctl, m_pcv, e_stall);
      end
      model_advance();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      run_req         = ($urandom_range(3) == 0);
      halt_in         = ($urandom_range(15) == 0);
      branch_taken_in = ($urandom_range(5) == 0);
      branch_tgt_in   = 24'($urandom);
      id_valid        = $urandom_range(1);
      id_src_used     = $urandom_range(1);
      id_src_gp       = GW'($urandom_range(3));
      id_tgt_used     = $urandom_range(1);
      id_tgt_gp       = GW'($urandom_range(3));
      ex_valid        = $urandom_range(1);
      ex_is_load      = $urandom_range(1);
      ex_wr_en        = $urandom_range(1);
      ex_tgt_gp       = GW'($urandom_range(3));
      #1;
      model_eval();
      n_run++;
      if ({act_ctl, pc_load_val, stall_cnt} !== {e_ctl, m_pcv, e_stall}) begin
        n_fail++;
        $display("FAIL random[%0d] ctl/pcv/stall act=%b/%h/%h req=%b/%h/%h",
                 c, act_ctl, pc_load_val, stall_cnt, e_ctl, m_pcv, e_stall);
      end
      model_advance();
    end
  endtask

  task automatic test_stall_saturate();
    for (int c = 0; c < 70000; c++) begin
      @(negedge clk);
      quiet_inputs();
      run_req = 1;
      load_r3_case(1'b1);
      #1;
      model_advance();
    end
    @(negedge clk);
    quiet_inputs();
    #1;
    model_eval();
    n_run++;
`ifdef PIPE_CTRL_STALL_CNT_EN
    if (stall_cnt !== 16'hFFFF || e_stall !== 16'hFFFF) begin
`else
    if (stall_cnt !== 16'h0000 || e_stall !== 16'h0000) begin
`endif
      n_fail++;
      $display("FAIL stall_saturate cnt act=%h req=%h", stall_cnt, e_stall);
    end
    model_advance();
  endtask

  task automatic test_reset_mid_flush();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      quiet_inputs();
      if (c == 0) begin
        branch_taken_in = 1; branch_tgt_in = 24'h5A5A5A;
      end
      #1;
      model_eval();
      n_run++;
      if ({act_ctl, pc_load_val, stall_cnt} !== {e_ctl, m_pcv, e_stall}) begin
        n_fail++;
        $display("FAIL mid_flush[%0d] ctl/pcv/stall act=%b/%h/%h req=%b/%h/%h",
                 c, act_ctl, pc_load_val, stall_cnt, e_ctl, m_pcv, e_stall);
      end
      if (c == 0) model_advance();
    end
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    n_run++;
    if ({act_ctl, pc_load_val, stall_cnt} !== {7'b0000001, 24'h0, 16'h0}) begin
      n_fail++;
      $display("FAIL reset_mid_flush ctl/pcv/stall act=%b/%h/%h req=%b/%h/%h",
               act_ctl, pc_load_val, stall_cnt, 7'b0000001, 24'h0, 16'h0);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    model_eval();
    n_run++;
    if ({act_ctl, pc_load_val, stall_cnt} !== {e_ctl, m_pcv, e_stall}) begin
      n_fail++;
      $display("FAIL after_reset ctl/pcv/stall act=%b/%h/%h req=%b/%h/%h",
               act_ctl, pc_load_val, stall_cnt, e_ctl, m_pcv, e_stall);
    end
  endtask

  initial begin
    rst = 1'b1;
    quiet_inputs();
    test_reset();
    test_start();
    test_load_use();
    test_branch_flush();
    test_halt_vs_branch();
    test_random();
    test_stall_saturate();
    test_reset_mid_flush();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
